// File: rtl/memory_xbar_pkg.sv
// Shared memory map and index constants for the multi-master memory crossbar.
// Default slave windows are inclusive base / exclusive limit; 0xFFFF itself
// is left unmapped because the limit must fit in AW bits.
package memory_xbar_pkg;

    localparam int DEF_NUM_M = 4;
    localparam int DEF_NUM_S = 6;
    localparam int DEF_AW    = 16;
    localparam int DEF_DW    = 8;

    typedef enum logic [1:0] {
        M_CPU  = 2'd0,
        M_PPU  = 2'd1,
        M_RDMA = 2'd2,
        M_WDMA = 2'd3
    } master_id_e;

    typedef enum logic [2:0] {
        S_IOREG     = 3'd0,
        S_CARTRIDGE = 3'd1,
        S_LCDRAM    = 3'd2,
        S_WRAM      = 3'd3,
        S_OAM       = 3'd4,
        S_LWRAM     = 3'd5
    } slave_id_e;

    localparam logic [15:0] IOREG_LO     = 16'hFF00;
    localparam logic [15:0] IOREG_HI     = 16'hFF80;
    localparam logic [15:0] CARTRIDGE_LO = 16'h0000;
    localparam logic [15:0] CARTRIDGE_HI = 16'h8000;
    localparam logic [15:0] LCDRAM_LO    = 16'h8000;
    localparam logic [15:0] LCDRAM_HI    = 16'hA000;
    localparam logic [15:0] WRAM_LO      = 16'hC000;
    localparam logic [15:0] WRAM_HI      = 16'hE000;
    localparam logic [15:0] OAM_LO       = 16'hFE00;
    localparam logic [15:0] OAM_HI       = 16'hFEA0;
    localparam logic [15:0] LWRAM_LO     = 16'hFF80;
    localparam logic [15:0] LWRAM_HI     = 16'hFFFF;

    // Slave 0 occupies the least significant AW bits.
    localparam logic [DEF_NUM_S*DEF_AW-1:0] DEF_S_BASE =
        {LWRAM_LO, OAM_LO, WRAM_LO, LCDRAM_LO, CARTRIDGE_LO, IOREG_LO};
    localparam logic [DEF_NUM_S*DEF_AW-1:0] DEF_S_LIMIT =
        {LWRAM_HI, OAM_HI, WRAM_HI, LCDRAM_HI, CARTRIDGE_HI, IOREG_HI};

endpackage

// File: rtl/memory_xbar_if.sv
// Bus bundle between the masters/slave memories and the crossbar.
// "master" is the environment side, "slave" is the crossbar side.
interface memory_xbar_if
    import memory_xbar_pkg::*;
#(
    parameter int NUM_M = DEF_NUM_M,
    parameter int NUM_S = DEF_NUM_S,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
);
    logic [NUM_M-1:0]    I_M_REQ;
    logic [NUM_M-1:0]    I_M_WE;
    logic [NUM_M*AW-1:0] I_M_ADDR;
    logic [NUM_M*DW-1:0] I_M_WDATA;
    logic [NUM_M-1:0]    O_M_GNT;
    logic [NUM_M-1:0]    O_M_RVALID;
    logic [NUM_M*DW-1:0] O_M_RDATA;
    logic [NUM_M-1:0]    O_M_DECERR;
    logic [NUM_S*AW-1:0] O_S_ADDR;
    logic [NUM_S*DW-1:0] O_S_WDATA;
    logic [NUM_S-1:0]    O_S_WE_L;
    logic [NUM_S-1:0]    O_S_RE_L;
    logic [NUM_S*DW-1:0] I_S_RDATA;
    logic                O_SAME_PORT_ACCESS_ERROR;
    logic [7:0]          O_CONFLICT_CNT;

    modport master (
        output I_M_REQ, I_M_WE, I_M_ADDR, I_M_WDATA, I_S_RDATA,
        input  O_M_GNT, O_M_RVALID, O_M_RDATA, O_M_DECERR,
               O_S_ADDR, O_S_WDATA, O_S_WE_L, O_S_RE_L,
               O_SAME_PORT_ACCESS_ERROR, O_CONFLICT_CNT
    );

    modport slave (
        input  I_M_REQ, I_M_WE, I_M_ADDR, I_M_WDATA, I_S_RDATA,
        output O_M_GNT, O_M_RVALID, O_M_RDATA, O_M_DECERR,
               O_S_ADDR, O_S_WDATA, O_S_WE_L, O_S_RE_L,
               O_SAME_PORT_ACCESS_ERROR, O_CONFLICT_CNT
    );
endinterface

// File: rtl/memory_xbar_arb.sv
// Request-to-one-hot-grant arbiter, one per slave.
// MEMXBAR_RR_ARB_EN: round-robin starting after the last granted master
// (pointer resets to NUM_M-1 so master 0 wins first). Otherwise fixed
// priority with master 0 highest and no state at all.
module mem_xbar_arb
    import memory_xbar_pkg::*;
#(
    parameter int NUM_M = DEF_NUM_M
) (
`ifdef MEMXBAR_RR_ARB_EN
    input  logic             clk,
    input  logic             rst,
`endif
    input  logic [NUM_M-1:0] req,
    output logic [NUM_M-1:0] gnt
);
`ifdef MEMXBAR_RR_ARB_EN
    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   cand;
    logic          found;

    // Search from the slot after the last winner, wrapping modulo NUM_M
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_M)) cand = cand - (IW+1)'(NUM_M);
            if (!found && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[IW-1:0]]    = 1'b1;
                ptr_d                = cand[IW-1:0];
            end
        end
    end

    // Pointer moves only when somebody is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= IW'(NUM_M - 1);
        else     ptr_q <= ptr_d;
    end
`else
    logic found;

    // Lowest requesting index wins
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/memory_xbar.sv
// Multi-master memory crossbar: per-master window decode, per-slave
// arbitration (see mem_xbar_arb, MEMXBAR_RR_ARB_EN selects round-robin),
// registered read-return routing, open-bus answer for unmapped reads,
// sticky same-slave conflict flag and saturating stall counter.
module memory_xbar
    import memory_xbar_pkg::*;
#(
    parameter int NUM_M = DEF_NUM_M,
    parameter int NUM_S = DEF_NUM_S,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter logic [NUM_S*AW-1:0] S_BASE  = DEF_S_BASE,
    parameter logic [NUM_S*AW-1:0] S_LIMIT = DEF_S_LIMIT
) (
    input logic          I_CLK,
    input logic          I_RESET,
    memory_xbar_if.slave bus
);
    localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;

    logic [NUM_M-1:0]    hit, miss, gnt;
    logic [SW-1:0]       sel     [NUM_M];
    logic [NUM_M-1:0]    slv_req [NUM_S];
    logic [NUM_M-1:0]    slv_gnt [NUM_S];
    logic [NUM_S*AW-1:0] s_addr;
    logic [NUM_S*DW-1:0] s_wdata;
    logic [NUM_S-1:0]    s_we_l, s_re_l;
    logic                multi, stall;
    logic [NUM_M*DW-1:0] rdata;

    logic [NUM_M-1:0]    rvalid_q, rvalid_d;
    logic [NUM_M-1:0]    rmiss_q, rmiss_d;
    logic [SW-1:0]       rsel_q  [NUM_M];
    logic [SW-1:0]       rsel_d  [NUM_M];
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;

    // Address decode; scanning downward lets the lowest matching slave win
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            hit[m] = 1'b0;
            sel[m] = '0;
            for (int s = NUM_S - 1; s >= 0; s--) begin
                if (bus.I_M_ADDR[m*AW +: AW] >= S_BASE[s*AW +: AW] &&
                    bus.I_M_ADDR[m*AW +: AW] <  S_LIMIT[s*AW +: AW]) begin
                    hit[m] = 1'b1;
                    sel[m] = SW'(s);
                end
            end
        end
    end

    // Per-slave request vectors feeding the arbiters
    always_comb begin
        for (int s = 0; s < NUM_S; s++) begin
            for (int m = 0; m < NUM_M; m++) begin
                slv_req[s][m] = bus.I_M_REQ[m] & hit[m] & (sel[m] == SW'(s));
            end
        end
    end

    for (genvar s = 0; s < NUM_S; s++) begin : g_arb
        mem_xbar_arb #(.NUM_M(NUM_M)) u_arb (
`ifdef MEMXBAR_RR_ARB_EN
            .clk (I_CLK),
            .rst (I_RESET),
`endif
            .req (slv_req[s]),
            .gnt (slv_gnt[s])
        );
    end

    // Combine grants, steer each winner onto its slave, flag contention
    always_comb begin
        miss    = bus.I_M_REQ & ~hit;
        gnt     = miss;
        s_addr  = '0;
        s_wdata = '0;
        s_we_l  = '1;
        s_re_l  = '1;
        multi   = 1'b0;
        for (int s = 0; s < NUM_S; s++) begin
            if ($countones(slv_req[s]) > 1) multi = 1'b1;
            for (int m = 0; m < NUM_M; m++) begin
                if (slv_gnt[s][m]) begin
                    gnt[m]              = 1'b1;
                    s_addr[s*AW +: AW]  = bus.I_M_ADDR[m*AW +: AW];
                    s_wdata[s*DW +: DW] = bus.I_M_WDATA[m*DW +: DW];
                    s_we_l[s]           = ~bus.I_M_WE[m];
                    s_re_l[s]           = bus.I_M_WE[m];
                end
            end
        end
        stall = |(bus.I_M_REQ & ~gnt);
    end

    // Next state: one return slot per master, refreshed every cycle
    always_comb begin
        rvalid_d = gnt & ~bus.I_M_WE;
        rmiss_d  = ~hit;
        rsel_d   = sel;
        err_d    = err_q | multi;
        cnt_d    = (stall && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    // Return slots, sticky error and stall counter
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            rvalid_q <= '0;
            rmiss_q  <= '0;
            for (int m = 0; m < NUM_M; m++) rsel_q[m] <= '0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            rvalid_q <= rvalid_d;
            rmiss_q  <= rmiss_d;
            rsel_q   <= rsel_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Route the addressed slave's data (or open-bus 0xFF) back to its master
    always_comb begin
        rdata = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (rvalid_q[m]) begin
                if (rmiss_q[m]) begin
                    rdata[m*DW +: DW] = {DW{1'b1}};
                end else begin
                    for (int s = 0; s < NUM_S; s++) begin
                        if (rsel_q[m] == SW'(s)) rdata[m*DW +: DW] = bus.I_S_RDATA[s*DW +: DW];
                    end
                end
            end
        end
    end

    assign bus.O_M_GNT                  = gnt;
    assign bus.O_M_DECERR               = miss;
    assign bus.O_M_RVALID               = rvalid_q;
    assign bus.O_M_RDATA                = rdata;
    assign bus.O_S_ADDR                 = s_addr;
    assign bus.O_S_WDATA                = s_wdata;
    assign bus.O_S_WE_L                 = s_we_l;
    assign bus.O_S_RE_L                 = s_re_l;
    assign bus.O_SAME_PORT_ACCESS_ERROR = err_q;
    assign bus.O_CONFLICT_CNT           = cnt_q;
endmodule
